// File: rtl/serial_operand_feeder_if.sv
// Bundle of the word-input handshake and the serial stream between the feeder
// and its neighbours. The master modport is the feeder itself: it accepts
// operand words and drives the serial stream. The slave modport is the peer
// side that presents operand words, applies hold and consumes the stream.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             hold;
  logic             adder_sync;
  logic             ser_a;
  logic             ser_b;
  logic             ser_cin;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    input  in_valid, in_a, in_b, in_cin, hold,
    output in_ready, adder_sync, ser_a, ser_b, ser_cin, ser_first, ser_last, busy
  );

  modport slave (
    output in_valid, in_a, in_b, in_cin, hold,
    input  in_ready, adder_sync, ser_a, ser_b, ser_cin, ser_first, ser_last, busy
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: takes a parallel operand pair plus carry-in over a
// valid/ready handshake and streams it LSB first into the serial adder. A
// one-cycle adder_sync pulse precedes bit 0 so the adder's bit counter starts
// aligned with the stream. hold freezes the stream while bits are shifting.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_operand_feeder_if.master bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  // state and datapath registers
  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             cin_r;
  logic             adder_sync_r;
  logic             ser_a_r;
  logic             ser_b_r;
  logic             ser_cin_r;
  logic             ser_first_r;
  logic             ser_last_r;
  logic             busy_r;

  // next-state values
  logic [1:0]       state_s;
  logic [CW-1:0]    cnt_s;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic             cin_s;
  logic             adder_sync_s;
  logic             ser_a_s;
  logic             ser_b_s;
  logic             ser_cin_s;
  logic             ser_first_s;
  logic             ser_last_s;
  logic             busy_s;

  // Next-state and next-output logic; outputs default to 0 so every exit to
  // IDLE clears the stream, and hold in SHIFT re-loads the current values.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    a_sh_s       = a_sh_r;
    b_sh_s       = b_sh_r;
    cin_s        = cin_r;
    adder_sync_s = 1'b0;
    ser_a_s      = 1'b0;
    ser_b_s      = 1'b0;
    ser_cin_s    = 1'b0;
    ser_first_s  = 1'b0;
    ser_last_s   = 1'b0;
    busy_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_s      = ST_SYNC;
          a_sh_s       = bus.in_a;
          b_sh_s       = bus.in_b;
          cin_s        = bus.in_cin;
          adder_sync_s = 1'b1;
          ser_cin_s    = bus.in_cin;
          busy_s       = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SYNC: begin
        // hold is deliberately ignored here: the sync pulse is always one cycle
        state_s     = ST_SHIFT;
        cnt_s       = CNT_ZERO;
        ser_a_s     = a_sh_r[0];
        ser_b_s     = b_sh_r[0];
        a_sh_s      = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_s      = {1'b0, b_sh_r[WIDTH-1:1]};
        ser_cin_s   = cin_r;
        ser_first_s = 1'b1;
        ser_last_s  = (CNT_ZERO == CNT_LAST);
        busy_s      = 1'b1;
      end

      ST_SHIFT: begin
        if (bus.hold) begin
          ser_a_s     = ser_a_r;
          ser_b_s     = ser_b_r;
          ser_cin_s   = ser_cin_r;
          ser_first_s = ser_first_r;
          ser_last_s  = ser_last_r;
          busy_s      = busy_r;
        end else if (cnt_r == CNT_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s       = cnt_r + CNT_ONE;
          ser_a_s     = a_sh_r[0];
          ser_b_s     = b_sh_r[0];
          a_sh_s      = {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_s      = {1'b0, b_sh_r[WIDTH-1:1]};
          ser_cin_s   = cin_r;
          ser_last_s  = (cnt_r == CNT_PENULT);
          busy_s      = 1'b1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, shift registers and registered outputs; reset aborts any word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      cin_r        <= 1'b0;
      adder_sync_r <= 1'b0;
      ser_a_r      <= 1'b0;
      ser_b_r      <= 1'b0;
      ser_cin_r    <= 1'b0;
      ser_first_r  <= 1'b0;
      ser_last_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      a_sh_r       <= a_sh_s;
      b_sh_r       <= b_sh_s;
      cin_r        <= cin_s;
      adder_sync_r <= adder_sync_s;
      ser_a_r      <= ser_a_s;
      ser_b_r      <= ser_b_s;
      ser_cin_r    <= ser_cin_s;
      ser_first_r  <= ser_first_s;
      ser_last_r   <= ser_last_s;
      busy_r       <= busy_s;
    end
  end

  // in_ready is the only combinational output: a word is taken only in IDLE
  assign bus.in_ready   = (state_r == ST_IDLE);
  assign bus.adder_sync = adder_sync_r;
  assign bus.ser_a      = ser_a_r;
  assign bus.ser_b      = ser_b_r;
  assign bus.ser_cin    = ser_cin_r;
  assign bus.ser_first  = ser_first_r;
  assign bus.ser_last   = ser_last_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder: a 4-bit instance for the handshake,
// hold, reset and busy-poke cases, and an 8-bit instance for the wide word.
// A small serial-adder model consumes the stream to check the resulting sum.
module tb_serial_operand_feeder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_operand_feeder_if #(.WIDTH(4)) bus4 ();
  serial_operand_feeder_if #(.WIDTH(8)) bus8 ();

  serial_operand_feeder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_operand_feeder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] y_m;
  logic       co_m;
  int         acc0;
  int         acc1;
  int         busy_cnt;
  logic       seen;
  logic       not_ready;
  logic       c_m;
  logic       s_m;

  // compare one observed value against its expected value
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // send one word to the 4-bit feeder and check every cycle of its stream;
  // poke_k raises in_valid during bit poke_k, hold_sync holds through SYNC
  task automatic send_word4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input int poke_k, input logic hold_sync,
                            output logic [3:0] y, output logic cout);
    logic c;
    logic s;
    y = 4'd0;
    check_val("idle_ready", 32'(bus4.in_ready), 32'd1);
    bus4.in_valid = 1'b1;
    bus4.in_a     = a;
    bus4.in_b     = b;
    bus4.in_cin   = cin;
    bus4.hold     = hold_sync;
    @(negedge clk);
    check_val("sync_pulse", 32'(bus4.adder_sync), 32'd1);
    check_val("sync_busy", 32'(bus4.busy), 32'd1);
    check_val("sync_ser_a", 32'(bus4.ser_a), 32'd0);
    check_val("sync_ser_cin", 32'(bus4.ser_cin), 32'(cin));
    check_val("sync_ready", 32'(bus4.in_ready), 32'd0);
    c = bus4.ser_cin;
    bus4.in_valid = 1'b0;
    bus4.in_a     = ~a;
    bus4.in_b     = ~b;
    bus4.in_cin   = ~cin;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("bit_a", 32'(bus4.ser_a), (32'(a) >> k) & 32'd1);
      check_val("bit_b", 32'(bus4.ser_b), (32'(b) >> k) & 32'd1);
      check_val("bit_cin", 32'(bus4.ser_cin), 32'(cin));
      check_val("bit_first", 32'(bus4.ser_first), 32'(k == 0));
      check_val("bit_last", 32'(bus4.ser_last), 32'(k == 3));
      check_val("bit_busy", 32'(bus4.busy), 32'd1);
      check_val("bit_sync", 32'(bus4.adder_sync), 32'd0);
      check_val("bit_ready", 32'(bus4.in_ready), 32'd0);
      s = bus4.ser_a ^ bus4.ser_b ^ c;
      c = (bus4.ser_a & bus4.ser_b) | (bus4.ser_a & c) | (bus4.ser_b & c);
      y = y | (4'(s) << k);
      bus4.hold     = 1'b0;
      bus4.in_valid = (k == poke_k);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check_val("end_busy", 32'(bus4.busy), 32'd0);
    check_val("end_ready", 32'(bus4.in_ready), 32'd1);
    check_val("end_ser_cin", 32'(bus4.ser_cin), 32'd0);
    check_val("end_last", 32'(bus4.ser_last), 32'd0);
    cout = c;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.in_a     = 4'h0;
    bus4.in_b     = 4'h0;
    bus4.in_cin   = 1'b0;
    bus4.hold     = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_a     = 8'h00;
    bus8.in_b     = 8'h00;
    bus8.in_cin   = 1'b0;
    bus8.hold     = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(bus4.in_ready), 32'd1);
    check_val("rst_busy", 32'(bus4.busy), 32'd0);
    check_val("rst_sync", 32'(bus4.adder_sync), 32'd0);
    check_val("rst_first", 32'(bus4.ser_first), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word B + 6 + 1 -> y=2, carry out 1
    send_word4(4'hB, 4'h6, 1'b1, -1, 1'b0, y_m[3:0], co_m);
    check_val("t1_sum", 32'(y_m[3:0]), 32'h2);
    check_val("t1_cout", 32'(co_m), 32'd1);

    // back-to-back: second word accepted exactly 6 cycles after the first
    acc0 = -1;
    acc1 = -1;
    bus4.in_valid = 1'b1;
    bus4.in_a     = 4'h3;
    bus4.in_b     = 4'h5;
    bus4.in_cin   = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      if (t > 0) @(negedge clk);
      if (bus4.in_ready && bus4.in_valid) begin
        if (acc0 < 0) acc0 = t;
        else if (acc1 < 0) acc1 = t;
      end
      check_val("b2b_ready", 32'(bus4.in_ready), 32'(t == 0 || t == 6 || t == 12));
      if (t == 1 || t == 7) check_val("b2b_sync", 32'(bus4.adder_sync), 32'd1);
      if (t >= 2 && t <= 5) begin
        check_val("b2b_w1_a", 32'(bus4.ser_a), (32'h3 >> (t - 2)) & 32'd1);
        check_val("b2b_w1_b", 32'(bus4.ser_b), (32'h5 >> (t - 2)) & 32'd1);
      end
      if (t >= 8 && t <= 11) begin
        check_val("b2b_w2_a", 32'(bus4.ser_a), 32'd1);
        check_val("b2b_w2_b", 32'(bus4.ser_b), 32'(t == 8));
      end
      if (t == 1) begin
        bus4.in_a = 4'hF;
        bus4.in_b = 4'h1;
      end
      if (t == 7) bus4.in_valid = 1'b0;
    end
    check_val("b2b_interval", 32'(acc1 - acc0), 32'd6);

    // hold for 3 cycles while bit 2 of A=A is on the wire
    check_val("hold_idle_ready", 32'(bus4.in_ready), 32'd1);
    bus4.in_valid = 1'b1;
    bus4.in_a     = 4'hA;
    bus4.in_b     = 4'h0;
    bus4.in_cin   = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check_val("hold_sync", 32'(bus4.adder_sync), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("hold_a", 32'(bus4.ser_a), (32'h42 >> i) & 32'd1);
      check_val("hold_last", 32'(bus4.ser_last), 32'(i == 6));
      check_val("hold_first", 32'(bus4.ser_first), 32'(i == 0));
      check_val("hold_busy", 32'(bus4.busy), 32'd1);
      bus4.hold = (i >= 2 && i <= 4);
    end
    @(negedge clk);
    check_val("hold_end_busy", 32'(bus4.busy), 32'd0);

    // reset during bit 1 aborts the word
    bus4.in_valid = 1'b1;
    bus4.in_a     = 4'hF;
    bus4.in_b     = 4'hF;
    bus4.in_cin   = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rstmid_bit1_a", 32'(bus4.ser_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstmid_ser_a", 32'(bus4.ser_a), 32'd0);
    check_val("rstmid_ser_b", 32'(bus4.ser_b), 32'd0);
    check_val("rstmid_ser_cin", 32'(bus4.ser_cin), 32'd0);
    check_val("rstmid_busy", 32'(bus4.busy), 32'd0);
    check_val("rstmid_ready", 32'(bus4.in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    seen      = 1'b0;
    not_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen      = seen | bus4.ser_first | bus4.ser_last | bus4.busy | bus4.adder_sync;
      not_ready = not_ready | ~bus4.in_ready;
    end
    check_val("rstmid_quiet", 32'(seen), 32'd0);
    check_val("rstmid_ready_after", 32'(not_ready), 32'd0);

    // in_valid poked while busy, hold high through SYNC: 5 + C -> y=1, cout 1
    send_word4(4'h5, 4'hC, 1'b0, 1, 1'b1, y_m[3:0], co_m);
    check_val("t5_sum", 32'(y_m[3:0]), 32'h1);
    check_val("t5_cout", 32'(co_m), 32'd1);

    // 8-bit word 81 + 7F -> y=00, cout 1, busy for 9 cycles
    check_val("w8_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.in_a     = 8'h81;
    bus8.in_b     = 8'h7F;
    bus8.in_cin   = 1'b0;
    busy_cnt = 0;
    c_m      = 1'b0;
    y_m      = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      if (bus8.busy) busy_cnt = busy_cnt + 1;
      if (i == 0) begin
        check_val("w8_sync", 32'(bus8.adder_sync), 32'd1);
        c_m = bus8.ser_cin;
      end
      if (i >= 1 && i <= 8) begin
        check_val("w8_a", 32'(bus8.ser_a), (32'h81 >> (i - 1)) & 32'd1);
        check_val("w8_b", 32'(bus8.ser_b), (32'h7F >> (i - 1)) & 32'd1);
        check_val("w8_last", 32'(bus8.ser_last), 32'(i == 8));
        s_m = bus8.ser_a ^ bus8.ser_b ^ c_m;
        c_m = (bus8.ser_a & bus8.ser_b) | (bus8.ser_a & c_m) | (bus8.ser_b & c_m);
        y_m = y_m | (8'(s_m) << (i - 1));
      end
    end
    check_val("w8_busy_cycles", 32'(busy_cnt), 32'd9);
    check_val("w8_sum", 32'(y_m), 32'h00);
    check_val("w8_cout", 32'(c_m), 32'd1);
    check_val("w8_end_ready", 32'(bus8.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
